// File: rtl/spi_slave_ctrl.sv
// SPI slave serial front end: MOSI frames -> {cmd, data} words for the RAM, RAM read data -> MISO.
// Define SPI_CMD_CHECK_EN to drop completed payloads whose command bits disagree with the frame type.
module spi_slave_ctrl #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int PW = ADDR_SIZE + 2;
  localparam int CW = $clog2(PW);
  localparam int TW = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [PW-2:0]        rx_shift_q, rx_shift_d;
  logic [PW-1:0]        rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_addr_done_q, rd_addr_done_d;
  logic                 frame_done_q, frame_done_d;
  logic                 tx_wait_q, tx_wait_d;
  logic [ADDR_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [TW-1:0]        tx_cnt_q, tx_cnt_d;
  logic                 miso_q, miso_d;

  logic [PW-1:0]        payload;
  logic                 cmd_ok;

  assign payload = {rx_shift_q, MOSI};

`ifdef SPI_CMD_CHECK_EN
  logic [1:0] cmd;
  assign cmd = payload[PW-1:PW-2];

  always_comb begin
    case (state_q)
      WRITE:     cmd_ok = ~cmd[1];
      READ_ADD:  cmd_ok = (cmd == 2'b10);
      READ_DATA: cmd_ok = (cmd == 2'b11);
      default:   cmd_ok = 1'b1;
    endcase
  end
`else
  assign cmd_ok = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    frame_done_d   = frame_done_q;
    tx_wait_d      = tx_wait_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    miso_d         = miso_q;

    case (state_q)
      IDLE: begin
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        bit_cnt_d    = '0;
        frame_done_d = 1'b0;
        if (!MOSI)               state_d = WRITE;
        else if (rd_addr_done_q) state_d = READ_DATA;
        else                     state_d = READ_ADD;
      end
      default: begin
        if (!frame_done_q) begin
          rx_shift_d = payload[PW-2:0];
          if (bit_cnt_q == CW'(PW - 1)) begin
            frame_done_d = 1'b1;
            if (cmd_ok) begin
              rx_data_d  = payload;
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
              if (state_q == READ_DATA) begin
                rd_addr_done_d = 1'b0;
                tx_wait_d      = 1'b1;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        // Only the first tx_valid after the read payload is taken; later strobes are ignored.
        if (tx_wait_q && tx_valid) begin
          tx_wait_d  = 1'b0;
          miso_d     = tx_data[ADDR_SIZE-1];
          tx_shift_d = {tx_data[ADDR_SIZE-2:0], 1'b0};
          tx_cnt_d   = TW'(ADDR_SIZE - 1);
        end else if (tx_cnt_q != '0) begin
          miso_d     = tx_shift_q[ADDR_SIZE-1];
          tx_shift_d = {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
          tx_cnt_d   = tx_cnt_q - 1'b1;
        end else begin
          miso_d = 1'b0;
        end
      end
    endcase

    // Abort overrides everything above, including a payload completing on the same edge.
    if (state_q != IDLE && SS_n) begin
      state_d        = IDLE;
      bit_cnt_d      = '0;
      rx_shift_d     = '0;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      rd_addr_done_d = rd_addr_done_q;
      frame_done_d   = 1'b0;
      tx_wait_d      = 1'b0;
      tx_shift_d     = '0;
      tx_cnt_d       = '0;
      miso_d         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
      frame_done_q   <= 1'b0;
      tx_wait_q      <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
      frame_done_q   <= frame_done_d;
      tx_wait_q      <= tx_wait_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      miso_q         <= miso_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
